// File: rtl/nttn_sequencer_pkg.sv
// Shared types and size expressions for the NTTN sequencer.
// Falls back to a small RING_DEPTH=4 / PE_DEPTH=1 build when the NTTN defines are absent.
`ifndef RING_DEPTH
`define RING_DEPTH 4
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 1
`endif
`ifndef RING_SIZE
`define RING_SIZE (1 << `RING_DEPTH)
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

package nttn_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_PULSE, S_STREAM, S_GAP, S_START, S_WAIT, S_DRAIN, S_TAIL
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD_TW = 2'b00,
        OP_NTT     = 2'b01,
        OP_INTT    = 2'b10,
        OP_RSVD    = 2'b11
    } op_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_NO_TW    = 1;
    localparam int ERR_BAD_OP   = 2;
    localparam int ERR_TIMEOUT  = 3;

    localparam int DEF_DATA_W    = `DATA_SIZE_ARB;
    localparam int DEF_RING_SIZE = `RING_SIZE;
    localparam int DEF_TW_WORDS  = ((2 ** (`RING_DEPTH - `PE_DEPTH)) - 1 + `PE_DEPTH) << `PE_DEPTH;
    localparam int CNT_W         = 24;

    // twiddle load carries w, winv and two parameter words
    function automatic logic [CNT_W-1:0] stream_len(input logic [1:0] op, input int tw, input int ring);
        if (op == OP_LOAD_TW) return CNT_W'(2 * tw + 2);
        return CNT_W'(ring);
    endfunction

endpackage

// File: rtl/nttn_seq_cnt.sv
// Loadable down-counter with zero flag; load has priority, holds at zero.
module nttn_seq_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt <= '0;
        else if (load)              cnt <= value;
        else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/nttn_sequencer.sv
// Command sequencer for one NTTN core: load pulses, din streaming, done wait, result drain.
// Optional WAIT_DONE watchdog enabled by the NTTSEQ_TIMEOUT_EN macro.
module nttn_sequencer
    import nttn_sequencer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RING_SIZE = DEF_RING_SIZE,
    parameter int TW_WORDS  = DEF_TW_WORDS,
    parameter int GAP_CYC   = 5,
`ifdef NTTSEQ_TIMEOUT_EN
    parameter int TIMEOUT   = 1 << 20,
`endif
    parameter int TAIL_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [3:0]        err,
    input  logic              err_clr,
    output logic              load_w,
    output logic              load_data,
    output logic              start,
    output logic              start_intt,
    output logic [DATA_W-1:0] din,
    input  logic              done,
    input  logic [DATA_W-1:0] dout
);
    // States: IDLE accept cmd | PULSE load pulse | STREAM din words | GAP idle before pulse/idle
    //         START start pulse | WAIT await done | DRAIN forward dout | TAIL quiet before IDLE
    state_t           state, next;
    logic [1:0]       op_q;
    logic             tw_loaded, tw_set, tw_clr, accept;
    logic [3:0]       set;
    logic             cnt_load, cnt_zero, to_zero;
    logic [CNT_W-1:0] cnt_val;

    nttn_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk(clk), .reset(reset), .load(cnt_load), .value(cnt_val), .dec(1'b1), .zero(cnt_zero)
    );

`ifdef NTTSEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    nttn_seq_cnt #(.W(TO_W)) u_timeout (
        .clk(clk), .reset(reset), .load(state == S_START), .value(TO_W'(TIMEOUT - 1)),
        .dec(state == S_WAIT), .zero(to_zero)
    );
`else
    assign to_zero = 1'b0;
`endif

    assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

    always_comb begin
        next     = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        set      = '0;
        tw_set   = 1'b0;
        tw_clr   = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                if (cmd_op == OP_RSVD)       set[ERR_BAD_OP] = 1'b1;
                else if (cmd_op != OP_LOAD_TW && !tw_loaded) set[ERR_NO_TW] = 1'b1;
                else                         next = S_PULSE;
            end
            S_PULSE: begin
                next     = S_STREAM;
                cnt_load = 1'b1;
                cnt_val  = stream_len(op_q, TW_WORDS, RING_SIZE) - 1'b1;
            end
            S_STREAM: if (!s_valid) begin
                next              = S_TAIL;
                set[ERR_UNDERRUN] = 1'b1;
                tw_clr            = (op_q == OP_LOAD_TW);
                cnt_load          = 1'b1;
                cnt_val           = CNT_W'(TAIL_CYC - 1);
            end else if (cnt_zero) begin
                next     = S_GAP;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(GAP_CYC - 1);
            end
            S_GAP: if (cnt_zero) begin
                if (op_q == OP_LOAD_TW) begin
                    next   = S_IDLE;
                    tw_set = 1'b1;
                end else begin
                    next = S_START;
                end
            end
            S_START: next = S_WAIT;
            S_WAIT: if (done) begin
                next     = S_DRAIN;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(RING_SIZE - 1);
            end else if (to_zero) begin
                next             = S_TAIL;
                set[ERR_TIMEOUT] = 1'b1;
                cnt_load         = 1'b1;
                cnt_val          = CNT_W'(TAIL_CYC - 1);
            end
            S_DRAIN: if (cnt_zero) begin
                next     = S_TAIL;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(TAIL_CYC - 1);
            end
            S_TAIL: if (cnt_zero) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // NTTN-facing outputs are registered, so din lands one cycle after its s_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            tw_loaded  <= 1'b0;
            err        <= '0;
            cmd_ready  <= 1'b0;
            load_w     <= 1'b0;
            load_data  <= 1'b0;
            start      <= 1'b0;
            start_intt <= 1'b0;
            din        <= '0;
        end else begin
            state <= next;
            if (accept) op_q <= cmd_op;
            if (tw_set)      tw_loaded <= 1'b1;
            else if (tw_clr) tw_loaded <= 1'b0;
            err        <= (err_clr ? 4'b0000 : err) | set;
            cmd_ready  <= (next == S_IDLE);
            load_w     <= (state == S_PULSE) && (op_q == OP_LOAD_TW);
            load_data  <= (state == S_PULSE) && (op_q != OP_LOAD_TW);
            start      <= (state == S_START) && (op_q == OP_NTT);
            start_intt <= (state == S_START) && (op_q == OP_INTT);
            din        <= (state == S_STREAM && s_valid) ? s_data : '0;
        end
    end

    assign s_ready = (state == S_STREAM);
    assign busy    = (state != S_IDLE);
    assign m_valid = (state == S_DRAIN);
    assign m_data  = m_valid ? dout : '0;
    assign m_last  = m_valid && cnt_zero;
endmodule

// File: tb/tb_nttn_sequencer.sv
// Directed bench for nttn_sequencer (RING_SIZE=16, TW_WORDS=16, 16-bit words).
module tb_nttn_sequencer;
    localparam int DW  = 16;
    localparam int RS  = 16;
    localparam int NTW = 34;

    logic          clk = 1'b0, reset = 1'b0;
    logic          cmd_valid = 1'b0, s_valid = 1'b0, err_clr = 1'b0, done = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] s_data = '0, dout = '0;
    logic          cmd_ready, s_ready, m_valid, m_last, busy;
    logic          load_w, load_data, start, start_intt;
    logic [DW-1:0] m_data, din;
    logic [3:0]    err;
    int            total = 0, bad = 0;

    nttn_sequencer #(
`ifdef NTTSEQ_TIMEOUT_EN
        .TIMEOUT(64),
`endif
        .GAP_CYC(5)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .busy(busy),
        .err(err), .err_clr(err_clr), .load_w(load_w), .load_data(load_data),
        .start(start), .start_intt(start_intt), .din(din), .done(done), .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int i);
        return 16'h1000 + DW'(i * 7);
    endfunction

    task automatic issue(input logic [1:0] op);
        @(negedge clk);
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // which: 0 load_w, 1 load_data, 2 start or start_intt
    task automatic wait_sig(input int which, input int lim, output int steps);
        steps = 0;
        while (steps < lim && !((which == 0 && load_w) || (which == 1 && load_data) ||
                                (which == 2 && (start || start_intt)))) begin
            @(negedge clk);
            steps++;
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = word(200 + i);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({cmd_ready, busy, s_ready, m_valid, load_w, load_data, start, start_intt} !== 8'h00 ||
            err !== 4'h0 || din !== '0)
            begin bad++; $display("FAIL reset_outputs: ready=%b busy=%b err=%h din=%h, required all 0", cmd_ready, busy, err, din); end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL reset_idle: ready=%b busy=%b, required 1 0", cmd_ready, busy); end
    endtask

    task automatic test_no_tw();
        int seen = 0;
        issue(2'b01);
        total++;
        if (err !== 4'b0010) begin bad++; $display("FAIL no_tw_err: err=%b, required 0010", err); end
        for (int k = 0; k < 12; k++) begin
            if (load_data || busy) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0 || cmd_ready !== 1'b1)
            begin bad++; $display("FAIL no_tw_drop: activity=%0d ready=%b, required 0 1", seen, cmd_ready); end
        clear_err();
    endtask

    task automatic test_load_tw();
        int n, errs = 0;
        issue(2'b00);
        wait_sig(0, 10, n);
        total++;
        if (n != 1) begin bad++; $display("FAIL tw_pulse_latency: %0d, required 1", n); end
        for (int i = 0; i < NTW; i++) begin
            if (s_ready !== 1'b1 || din !== (i == 0 ? 16'h0000 : word(i - 1)) || (i > 0 && load_w !== 1'b0)) errs++;
            s_data  = word(i);
            s_valid = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++;
        if (errs != 0) begin bad++; $display("FAIL tw_stream: %0d bad cycles, required 0", errs); end
        total++;
        if (din !== word(NTW - 1) || s_ready !== 1'b0)
            begin bad++; $display("FAIL tw_last: din=%h s_ready=%b, required %h 0", din, s_ready, word(NTW - 1)); end
        errs = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5 && (cmd_ready !== 1'b0 || din !== '0)) errs++;
            if (k == 5 && (cmd_ready !== 1'b1 || busy !== 1'b0)) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL tw_gap: %0d bad cycles, required 0", errs); end
    endtask

    task automatic test_ntt();
        int n, errs = 0, early = 0;
        issue(2'b01);
        wait_sig(1, 10, n);
        total++;
        if (n != 1) begin bad++; $display("FAIL ntt_pulse_latency: %0d, required 1", n); end
        for (int i = 0; i < RS; i++) begin
            if (s_ready !== 1'b1 || din !== (i == 0 ? 16'h0000 : word(100 + i - 1))) errs++;
            s_data  = word(100 + i);
            s_valid = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++;
        if (errs != 0) begin bad++; $display("FAIL ntt_stream: %0d bad cycles, required 0", errs); end
        wait_sig(2, 20, n);
        total++;
        if (n != 6 || start !== 1'b1 || start_intt !== 1'b0)
            begin bad++; $display("FAIL ntt_start: gap=%0d start=%b intt=%b, required 6 1 0", n, start, start_intt); end
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (m_valid) early++;
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        errs = 0;
        for (int i = 0; i < RS; i++) begin
            dout = 16'hB000 + DW'(i);
            #1;
            if (m_valid !== 1'b1 || m_data !== 16'hB000 + DW'(i) || m_last !== (i == RS - 1)) errs++;
            if (i < RS - 1) @(negedge clk);
        end
        total++;
        if (errs != 0 || early != 0)
            begin bad++; $display("FAIL ntt_drain: %0d bad words, %0d early, required 0 0", errs, early); end
        errs = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 10 && (cmd_ready !== 1'b0 || m_valid !== 1'b0)) errs++;
            if (k == 11 && cmd_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL ntt_tail: %0d bad cycles, required 0", errs); end
    endtask

    task automatic test_underrun();
        int n, errs = 0, seen = 0;
        issue(2'b10);
        wait_sig(1, 10, n);
        for (int i = 0; i < 8; i++) begin
            s_valid = (i < 7);
            s_data  = word(300 + i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++;
        if (err !== 4'b0001 || s_ready !== 1'b0)
            begin bad++; $display("FAIL underrun_err: err=%b s_ready=%b, required 0001 0", err, s_ready); end
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            if (start_intt) seen++;
            if (k <= 10 && cmd_ready !== 1'b0) errs++;
            if (k == 11 && cmd_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0 || seen != 0)
            begin bad++; $display("FAIL underrun_tail: %0d bad cycles, %0d start_intt, required 0 0", errs, seen); end
        clear_err();
        total++;
        if (err !== 4'b0000) begin bad++; $display("FAIL err_clr: err=%b, required 0000", err); end
    endtask

    task automatic test_bad_op();
        issue(2'b11);
        total++;
        if (err !== 4'b0100 || busy !== 1'b0)
            begin bad++; $display("FAIL bad_op: err=%b busy=%b, required 0100 0", err, busy); end
        clear_err();
    endtask

`ifdef NTTSEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n, errs = 0, mv = 0;
        issue(2'b01);
        wait_sig(1, 10, n);
        feed(RS);
        wait_sig(2, 20, n);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (m_valid) mv++;
            if (k == 63 && (err[3] !== 1'b0 || busy !== 1'b1)) errs++;
            if (k == 64 && err[3] !== 1'b1) errs++;
        end
        n = 0;
        while (!cmd_ready && n < 30) begin
            @(negedge clk);
            if (m_valid) mv++;
            n++;
        end
        total++;
        if (errs != 0 || mv != 0 || n != 10)
            begin bad++; $display("FAIL timeout: errs=%0d m_valid=%0d tail=%0d, required 0 0 10", errs, mv, n); end
        clear_err();
    endtask
`endif

    task automatic test_reset_drain();
        int n, seen = 0;
        issue(2'b01);
        wait_sig(1, 10, n);
        feed(RS);
        wait_sig(2, 20, n);
        repeat (20) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0)
            begin bad++; $display("FAIL reset_drain: m_valid=%b busy=%b ready=%b, required 0 0 0", m_valid, busy, cmd_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(2'b01);
        for (int k = 0; k < 10; k++) begin
            if (load_data || busy) seen++;
            @(negedge clk);
        end
        total++;
        if (err !== 4'b0010 || seen != 0)
            begin bad++; $display("FAIL reset_tw_cleared: err=%b activity=%0d, required 0010 0", err, seen); end
    endtask

    initial begin
        test_reset();
        test_no_tw();
        test_load_tw();
        test_ntt();
        test_underrun();
        test_bad_op();
`ifdef NTTSEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nttn_sequencer.md
Name: nttn_sequencer

Overview:
- Controller that sequences one NTTN core from a command port plus input/output word streams.
- On each command it generates the NTTN load/start pulses, streams twiddles, parameters and polynomial coefficients into `din` with exact cycle timing, and waits for `done`.
- It then forwards the RING_SIZE result words from `dout` to the output stream.
- It sits between the host/DMA interface and NTTN; NTTN itself has no backpressure, so all flow control lives here.

Parameters:
- DATA_W, `DATA_SIZE_ARB: coefficient/twiddle word width.
- RING_SIZE, `RING_SIZE: coefficients per polynomial.
- TW_WORDS, ((2^(`RING_DEPTH-`PE_DEPTH))-1+`PE_DEPTH)<<`PE_DEPTH: words per twiddle table (w, and separately winv).
- GAP_CYC, 5: idle cycles between the end of any load stream and the next pulse.
- TAIL_CYC, 10: idle cycles after the last output word before the sequencer accepts the next command.
- TIMEOUT, 1<<20: WAIT_DONE watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  2  00 LOAD_TW, 01 NTT, 10 INTT, 11 reserved.
- s_valid  in  1  input word valid.
- s_ready  out  1  sequencer consuming an input word this cycle.
- s_data  in  DATA_W  input word.
- m_valid  out  1  result word valid; no backpressure.
- m_data  out  DATA_W  result word.
- m_last  out  1  high with result word RING_SIZE-1.
- busy  out  1  sequencer not in IDLE.
- err  out  4  sticky flags: [0] underrun, [1] no-twiddle, [2] bad op, [3] timeout.
- err_clr  in  1  clears err (synchronous).
- load_w, load_data, start, start_intt  out  1  one-cycle pulses to NTTN.
- din  out  DATA_W  data to NTTN.
- done  in  1  NTTN completion.
- dout  in  DATA_W  NTTN result stream.

Behaviour:
- Reset: all outputs 0; state IDLE; tw_loaded=0; err=0.
- IDLE:
  - cmd_ready=1.
  - op 11: dropped, err[2] set.
  - NTT/INTT with tw_loaded=0: dropped, err[1] set.
- LOAD_TW sequence:
  - PULSE: load_w=1, din=0 for one cycle.
  - TW_STREAM: exactly 2*TW_WORDS+2 consecutive cycles. Words are w, then winv, then two params; one word per cycle; din registered from s_data; s_ready=1 in each of these cycles.
  - GAP: GAP_CYC cycles, then IDLE with tw_loaded=1.
- NTT/INTT sequence:
  - PULSE: load_data=1 for one cycle.
  - DATA_STREAM: RING_SIZE consecutive words, as above.
  - GAP: GAP_CYC cycles.
  - START: start (NTT) or start_intt (INTT) = 1 for one cycle, din=0.
  - WAIT_DONE: wait for done.
  - DRAIN: starts the cycle after done is sampled high. For RING_SIZE cycles, m_valid=1 and m_data=dout (combinational pass, same cycle); m_last on the final word.
  - TAIL: TAIL_CYC cycles, then IDLE.
- Pulse-to-stream timing: the first stream word is on din the cycle after the pulse.
- Underrun: s_valid=0 in any stream cycle aborts to TAIL with err[0] set. A partial twiddle load clears tw_loaded. The pulse is never reissued automatically.
- cmd_ready=0 in all non-IDLE states; busy = (state != IDLE).
- done outside WAIT_DONE: ignored.
- err_clr and a set event in the same cycle: set wins.
- Asynchronous reset mid-operation: immediate return to IDLE, pulses deasserted, tw_loaded=0.

Optional Feature:
- Macro NTTSEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DONE. Reaching TIMEOUT cycles sets err[3] and goes to TAIL with no m_valid.
- Undefined: the counter is absent, WAIT_DONE waits indefinitely, and err[3] is tied to 0.

Decomposition:
- Shared package: state encoding, cmd_op constants, err bit indices, TW_WORDS/stream-length expressions derived from the `defines.v macros.
- One natural sub-module: nttn_seq_cnt, a loadable down-counter with a zero flag, reused for stream, gap, drain and tail lengths.

Test Plan:
Test configuration: RING_DEPTH=4, PE_DEPTH=1, so TW_WORDS=16 and RING_SIZE=16.
- Reset, then NTT cmd -> cmd dropped, err=4'b0010, no load_data pulse, busy stays 0.
- LOAD_TW with 34 contiguous words -> load_w pulse, then din = each word one cycle after its s_data, 34 s_ready cycles, 5-cycle gap, then tw_loaded=1.
- NTT with 16 words; NTTN model asserts done 100 cycles after start -> load_data pulse, start exactly 6 cycles after the last word, 16 m_valid words starting the cycle after done, m_last on word 15, cmd_ready returns 10 cycles later.
- INTT with s_valid dropped at word 7 -> err[0]=1, no start_intt, idle after 10 tail cycles; err_clr then reads err=0.
- cmd_op=11 -> err[2]=1; with NTTSEQ_TIMEOUT_EN and TIMEOUT=64, a model that never asserts done gives err[3]=1 after 64 cycles and no m_valid.
- Assert reset mid-DRAIN -> m_valid=0 immediately; a following NTT is rejected with err[1] because tw_loaded was cleared.
